// File: rtl/nt_sig_pkg.sv
// Shared types and MISR arithmetic for the Nt-node signature monitor.
package nt_sig_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Widest MISR the step function supports; narrower MISRs use the low bits.
  localparam int MAX_SIG_W = 64;
  localparam logic [MAX_SIG_W-1:0] POLY = 64'h1021;
  localparam logic [MAX_SIG_W-1:0] SEED = '1;

  function automatic logic [MAX_SIG_W-1:0] misr_step(
    input logic [MAX_SIG_W-1:0] sig,
    input logic                 din,
    input int                   w
  );
    logic [MAX_SIG_W-1:0] mask;
    logic [MAX_SIG_W-1:0] top;
    mask = (w >= MAX_SIG_W) ? '1 : ((64'd1 << w) - 64'd1);
    top  = sig >> (w - 1);
    return (((sig << 1) ^ (top[0] ? POLY : '0)) & mask)
           ^ {{(MAX_SIG_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/nt_sig_misr.sv
// Seedable MISR register; o_next is the value one step ahead of o_sig.
module nt_sig_misr
  import nt_sig_pkg::*;
#(
  parameter int SIG_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_seed,
  input  logic             i_step_en,
  input  logic             i_din,
  output logic [SIG_W-1:0] o_sig,
  output logic [SIG_W-1:0] o_next
);

  logic [SIG_W-1:0]     r_sig;
  logic [MAX_SIG_W-1:0] w_ext;
  logic [MAX_SIG_W-1:0] w_step;
  logic                 w_unused;

  assign w_ext    = MAX_SIG_W'(r_sig);
  assign w_step   = misr_step(w_ext, i_din, SIG_W);
  assign w_unused = ^w_step;
  assign o_next   = w_step[SIG_W-1:0];
  assign o_sig    = r_sig;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load_seed) r_sig <= SEED[SIG_W-1:0];
    else if (i_step_en)       r_sig <= o_next;
  end

endmodule

// File: rtl/nt_node_signature_monitor.sv
// Windowed response analyser: MISR signature, ones/toggle counts and
// end-of-window golden-mismatch and rarity flags for one observed node.
module nt_node_signature_monitor
  import nt_sig_pkg::*;
#(
  parameter  int WIN_LEN = 1000,
  parameter  int SIG_W   = 16,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             node_in,
  input  logic             node_valid,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic [CNT_W-1:0] rare_thresh,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             mismatch,
  output logic             rare_flag
);

  localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIN_LEN - 1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_ones, r_tog, r_smp;
  logic             r_prev, r_prev_valid, r_mismatch, r_rare;

  logic             w_load, w_accept, w_last, w_rare;
  logic [CNT_W-1:0] w_ones_nx, w_zeros_nx, w_min;
  logic [SIG_W-1:0] w_sig, w_sig_nx;

  assign w_load   = (r_state == IDLE) && start;
  assign w_accept = (r_state == RUN) && node_valid;
  assign w_last   = w_accept && (r_smp == LAST_C);

  nt_sig_misr #(.SIG_W(SIG_W)) u_misr (
    .i_clk       (I1470_clk),
    .i_rst       (I1477_rst),
    .i_load_seed (w_load),
    .i_step_en   (w_accept),
    .i_din       (node_in),
    .o_sig       (w_sig),
    .o_next      (w_sig_nx)
  );

  // Flags judge the window including the sample landing on the final edge.
  assign w_ones_nx  = r_ones + CNT_W'(node_in);
  assign w_zeros_nx = WIN_C - w_ones_nx;
  assign w_min      = (w_ones_nx < w_zeros_nx) ? w_ones_nx : w_zeros_nx;
  assign w_rare     = w_min < rare_thresh;

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) r_state <= IDLE;
    else           r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nx = RUN;
      RUN:     if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst || w_load) begin
      r_ones       <= '0;
      r_tog        <= '0;
      r_smp        <= '0;
      r_prev       <= 1'b0;
      r_prev_valid <= 1'b0;
      r_mismatch   <= 1'b0;
      r_rare       <= 1'b0;
    end else if (w_accept) begin
      r_ones       <= w_ones_nx;
      if (r_prev_valid && (node_in != r_prev)) r_tog <= r_tog + 1'b1;
      r_prev       <= node_in;
      r_prev_valid <= 1'b1;
      r_smp        <= r_smp + 1'b1;
      if (w_last) begin
        r_mismatch <= (w_sig_nx != golden_sig);
        r_rare     <= w_rare;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign signature  = w_sig;
  assign ones_cnt   = r_ones;
  assign toggle_cnt = r_tog;
  assign mismatch   = r_mismatch;
  assign rare_flag  = r_rare;

endmodule

// File: tb/tb_nt_node_signature_monitor.sv
// Bench: WIN_LEN=1 and WIN_LEN=8 monitors against a sample-list reference model.
module tb_nt_node_signature_monitor;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start1 = 1'b0, start8 = 1'b0, node_in = 1'b0, node_valid = 1'b0;
  logic [15:0] golden = 16'h0;
  logic [0:0]  th1 = '0;
  logic [3:0]  th8 = '0;

  logic        busy1, done1, mm1, rf1, busy8, done8, mm8, rf8;
  logic [15:0] sig1, sig8;
  logic [0:0]  ones1, tog1;
  logic [3:0]  ones8, tog8;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  nt_node_signature_monitor #(.WIN_LEN(1), .SIG_W(16)) dut1 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start1), .node_in(node_in),
    .node_valid(node_valid), .golden_sig(golden), .rare_thresh(th1),
    .busy(busy1), .done(done1), .signature(sig1), .ones_cnt(ones1),
    .toggle_cnt(tog1), .mismatch(mm1), .rare_flag(rf1));

  nt_node_signature_monitor #(.WIN_LEN(8), .SIG_W(16)) dut8 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start8), .node_in(node_in),
    .node_valid(node_valid), .golden_sig(golden), .rare_thresh(th8),
    .busy(busy8), .done(done8), .signature(sig8), .ones_cnt(ones8),
    .toggle_cnt(tog8), .mismatch(mm8), .rare_flag(rf8));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the window is the list of accepted samples; outputs are
  // derived from that list directly.
  function automatic logic [15:0] fold(input logic [7:0] s, input int cnt);
    logic [15:0] v;
    logic        msb;
    v = 16'hFFFF;
    for (int i = 0; i < cnt; i++) begin
      msb = v[15];
      v = (v << 1) ^ (msb ? 16'h1021 : 16'h0) ^ {15'b0, s[i]};
    end
    return v;
  endfunction

  function automatic int ones_of(input logic [7:0] s, input int cnt);
    int c;
    c = 0;
    for (int i = 0; i < cnt; i++) c += int'(s[i]);
    return c;
  endfunction

  function automatic int tog_of(input logic [7:0] s, input int cnt);
    int c;
    c = 0;
    for (int i = 1; i < cnt; i++) if (s[i] != s[i-1]) c++;
    return c;
  endfunction

  int          ph[2]  = '{0, 0};
  int          n[2]   = '{0, 0};
  int          WL[2]  = '{1, 8};
  logic [7:0]  smp[2] = '{8'h0, 8'h0};
  bit          mmm[2] = '{1'b0, 1'b0};
  bit          rfm[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   th, o, z;
      logic st;
      th = (k == 1) ? int'(th8) : int'(th1);
      st = (k == 1) ? start8 : start1;
      if (rst) begin
        ph[k] = 0; n[k] = 0; smp[k] = 8'h0; mmm[k] = 1'b0; rfm[k] = 1'b0;
      end else if (ph[k] == 0) begin
        if (st) begin
          ph[k] = 1; n[k] = 0; smp[k] = 8'h0; mmm[k] = 1'b0; rfm[k] = 1'b0;
        end
      end else if (ph[k] == 1) begin
        if (node_valid) begin
          smp[k][3'(n[k])] = node_in;
          n[k]++;
          if (n[k] == WL[k]) begin
            ph[k]  = 2;
            o      = ones_of(smp[k], n[k]);
            z      = WL[k] - o;
            mmm[k] = (fold(smp[k], n[k]) != golden);
            rfm[k] = (((o < z) ? o : z) < th);
          end
        end
      end else begin
        ph[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy1", int'(busy1), int'(ph[0] != 0));
    chk("done1", int'(done1), int'(ph[0] == 2));
    chk("sig1",  int'(sig1),  int'(fold(smp[0], n[0])));
    chk("ones1", int'(ones1), ones_of(smp[0], n[0]));
    chk("tog1",  int'(tog1),  tog_of(smp[0], n[0]));
    chk("mm1",   int'(mm1),   int'(mmm[0]));
    chk("rf1",   int'(rf1),   int'(rfm[0]));
    chk("busy8", int'(busy8), int'(ph[1] != 0));
    chk("done8", int'(done8), int'(ph[1] == 2));
    chk("sig8",  int'(sig8),  int'(fold(smp[1], n[1])));
    chk("ones8", int'(ones8), ones_of(smp[1], n[1]));
    chk("tog8",  int'(tog8),  tog_of(smp[1], n[1]));
    chk("mm8",   int'(mm8),   int'(mmm[1]));
    chk("rf8",   int'(rf8),   int'(rfm[1]));
  end

  // Runs one window; returns edges from the start edge to the last-sample edge.
  // On return the bench sits at the negedge where done must be high.
  task automatic win(input int k, input logic [7:0] bits, input bit alt,
                     input int mid_start, output int e);
    @(negedge clk);
    if (k == 1) start8 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    e = 0;
    for (int i = 0; i < WL[k]; i++) begin
      if (alt && i > 0) begin
        node_valid = 1'b0;
        @(negedge clk); e++;
      end
      node_valid = 1'b1;
      node_in    = bits[i];
      if (i == mid_start) begin
        if (k == 1) start8 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk); e++;
      start1 = 1'b0; start8 = 1'b0;
    end
    node_valid = 1'b0;
  endtask

  initial begin
    int          e;
    logic [15:0] s_ref;
    logic [7:0]  stream;
    stream = 8'b0011_1010;  // 0,1,0,1,1,1,0,0 in sample order

    repeat (2) @(negedge clk);
    chk("rst_sig8", int'(sig8), 16'hFFFF);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_ones8", int'(ones8), 0);
    rst = 1'b0;

    win(0, 8'h00, 1'b0, -1, e);
    chk("w1z_done", int'(done1), 1);
    chk("w1z_sig", int'(sig1), 16'hEFDF);
    chk("w1z_lat", e, 1);
    win(0, 8'h01, 1'b0, -1, e);
    chk("w1o_sig", int'(sig1), 16'hEFDE);
    chk("w1o_ones", int'(ones1), 1);

    win(1, stream, 1'b0, -1, e);
    chk("w8_done", int'(done8), 1);
    chk("w8_ones", int'(ones8), 4);
    chk("w8_tog", int'(tog8), 4);
    chk("w8_lat", e, 8);
    s_ref = sig8;
    @(negedge clk);
    chk("w8_busy_off", int'(busy8), 0);

    win(1, stream, 1'b1, -1, e);
    chk("alt_done", int'(done8), 1);
    chk("alt_ones", int'(ones8), 4);
    chk("alt_tog", int'(tog8), 4);
    chk("alt_sig", int'(sig8), int'(s_ref));
    chk("alt_lat", e, 15);

    golden = fold(8'h00, 8);
    th8    = 4'd2;
    win(1, 8'h00, 1'b0, -1, e);
    chk("rare_rf", int'(rf8), 1);
    chk("rare_mm", int'(mm8), 0);
    golden = golden ^ 16'h0001;
    win(1, 8'h00, 1'b0, -1, e);
    chk("flip_mm", int'(mm8), 1);

    win(1, stream, 1'b0, 3, e);
    chk("mid_start_done", int'(done8), 1);
    chk("mid_start_lat", e, 8);

    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; node_valid = 1'b1; node_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; node_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", int'(busy8), 0);
    chk("abort_done", int'(done8), 0);
    chk("abort_sig", int'(sig8), 16'hFFFF);
    chk("abort_ones", int'(ones8), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    win(1, stream, 1'b0, -1, e);
    chk("post_abort_done", int'(done8), 1);
    chk("post_abort_ones", int'(ones8), 4);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 149) == 0);
      start1     = ($urandom_range(0, 5) == 0);
      start8     = ($urandom_range(0, 5) == 0);
      node_valid = ($urandom_range(0, 2) != 0);
      node_in    = 1'($urandom);
      th1        = 1'($urandom);
      th8        = 4'($urandom_range(0, 9));
      golden     = ($urandom_range(0, 3) == 0) ? fold(8'h00, 8) : 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0; start8 = 1'b0; node_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
